// File: rtl/i2c_target_multi.sv
// I2C target answering NUM_ADDR consecutive 7-bit addresses starting at BASE_ADDR.
// Byte-level valid/ready handshakes towards fabric; SDA is driven open-drain through i2c_sda_oe.
module i2c_target_multi #(
  parameter logic [6:0] BASE_ADDR   = 7'h66,
  parameter int         NUM_ADDR    = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_DEFAULT  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [2:0] sel_o,
  output logic       rw_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       tx_nack_o,
  output logic       tx_underrun_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_SKIP     = 3'd7;

  localparam logic [7:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [7:0] ADDR_HI = ADDR_LO + 8'(NUM_ADDR);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] tx_shift;
  logic       sda_oe_q;
  logic       matched;

  logic [7:0] byte_in;
  logic [7:0] addr_ext;
  logic       addr_match;
  logic [2:0] sel_next;
  logic [7:0] tx_byte;

  // Synchronisers and edge history reset to 1 (idle bus) so reset release creates no edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = ~sda_s & sda_prev & scl_s;
  assign stop_det  = sda_s & ~sda_prev & scl_s;

  assign byte_in  = {shift_reg[6:0], sda_s};
  assign addr_ext = {1'b0, byte_in[7:1]};
  // General call (0x00) is never answered, even if the window would cover it.
  assign addr_match = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI) && (addr_ext != 8'd0);
  // Within the window the offset is below 8, so low-bit subtraction gives the index.
  assign sel_next = byte_in[3:1] - BASE_ADDR[2:0];
  assign tx_byte  = tx_valid_i ? tx_data_i : TX_DEFAULT;

  assign i2c_sda_o  = 1'b0;
  assign i2c_sda_oe = sda_oe_q;

  // Main protocol engine; START/STOP override whatever state the byte engine is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      shift_reg     <= 8'd0;
      tx_shift      <= 8'd0;
      sda_oe_q      <= 1'b0;
      matched       <= 1'b0;
      rx_data_o     <= 8'd0;
      rx_valid_o    <= 1'b0;
      tx_ready_o    <= 1'b0;
      sel_o         <= 3'd0;
      rw_o          <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      tx_nack_o     <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_ready_o    <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      tx_nack_o     <= 1'b0;
      tx_underrun_o <= 1'b0;

      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 3'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        bit_cnt  <= 3'd0;
        sda_oe_q <= 1'b0;
        stop_o   <= matched;
        matched  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= byte_in;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_match) begin
                  start_o <= 1'b1;
                  sel_o   <= sel_next;
                  rw_o    <= byte_in[0];
                  matched <= 1'b1;
                  state   <= ST_ADDR_ACK;
                end else begin
                  state <= ST_SKIP;
                end
              end
            end
          end

          // First fall starts the ACK, second fall ends it.
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (rw_o) begin
                tx_shift      <= tx_byte;
                sda_oe_q      <= ~tx_byte[7];
                tx_ready_o    <= tx_valid_i;
                tx_underrun_o <= ~tx_valid_i;
                bit_cnt       <= 3'd0;
                state         <= ST_RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ST_WR_DATA;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_reg <= byte_in;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_ready_i) begin
                  rx_data_o  <= byte_in;
                  rx_valid_o <= 1'b1;
                  state      <= ST_WR_ACK;
                end else begin
                  state <= ST_SKIP;
                end
              end
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ST_WR_DATA;
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe_q <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ST_RD_ACK;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                sda_oe_q <= ~tx_shift[6];
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          // Any fall seen here follows an ACKed 9th rise, since a NACK leaves the state.
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                tx_nack_o <= 1'b1;
                state     <= ST_SKIP;
              end
            end else if (scl_fall) begin
              tx_shift      <= tx_byte;
              sda_oe_q      <= ~tx_byte[7];
              tx_ready_o    <= tx_valid_i;
              tx_underrun_o <= ~tx_valid_i;
              bit_cnt       <= 3'd0;
              state         <= ST_RD_DATA;
            end
          end

          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_multi.sv
// Directed bench for i2c_target_multi: bit-banged I2C controller on a wired-AND SDA line,
// pulse counters sampled on the falling clock edge, immediate assertions at each check.
module tb_i2c_target_multi;

  localparam int Q = 8;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       sda_drv;
  logic       sda_line;
  logic       i2c_sda_o;
  logic       i2c_sda_oe;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [2:0] sel_o;
  logic       rw_o;
  logic       start_o;
  logic       stop_o;
  logic       tx_nack_o;
  logic       tx_underrun_o;

  int errors = 0;
  int checks = 0;

  int cnt_start = 0, cnt_stop = 0, cnt_rx = 0, cnt_txr = 0, cnt_und = 0, cnt_nack = 0, cnt_oe = 0;
  int s_start, s_stop, s_rx, s_txr, s_und, s_nack, s_oe;
  logic [7:0] rx_log [16];

  assign sda_line = sda_drv & ~i2c_sda_oe;

  i2c_target_multi #(
    .BASE_ADDR  (7'h66),
    .NUM_ADDR   (4),
    .SYNC_STAGES(2),
    .TX_DEFAULT (8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i2c_scl_i    (scl),
    .i2c_sda_i    (sda_line),
    .i2c_sda_o    (i2c_sda_o),
    .i2c_sda_oe   (i2c_sda_oe),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .sel_o        (sel_o),
    .rw_o         (rw_o),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .tx_nack_o    (tx_nack_o),
    .tx_underrun_o(tx_underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (start_o)       cnt_start <= cnt_start + 1;
      if (stop_o)        cnt_stop  <= cnt_stop + 1;
      if (tx_ready_o)    cnt_txr   <= cnt_txr + 1;
      if (tx_underrun_o) cnt_und   <= cnt_und + 1;
      if (tx_nack_o)     cnt_nack  <= cnt_nack + 1;
      if (i2c_sda_oe)    cnt_oe    <= cnt_oe + 1;
      if (rx_valid_o) begin
        rx_log[cnt_rx[3:0]] <= rx_data_o;
        cnt_rx <= cnt_rx + 1;
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL timeout: simulation did not finish within 1 ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic tv, input logic [7:0] td);
    rx_ready_i = rdy;
    tx_valid_i = tv;
    tx_data_i  = td;
  endtask

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic snap;
    s_start = cnt_start; s_stop = cnt_stop; s_rx = cnt_rx; s_txr = cnt_txr;
    s_und = cnt_und; s_nack = cnt_nack; s_oe = cnt_oe;
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; scl = 1'b1; wait_q;
    sda_drv = 1'b0; wait_q;
    scl = 1'b0; wait_q;
  endtask

  task automatic i2c_rstart;
    sda_drv = 1'b1; wait_q;
    scl = 1'b1; wait_q;
    sda_drv = 1'b0; wait_q;
    scl = 1'b0; wait_q;
  endtask

  task automatic i2c_stop;
    sda_drv = 1'b0; wait_q;
    scl = 1'b1; wait_q;
    sda_drv = 1'b1; wait_q; wait_q;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; wait_q;
    scl = 1'b1; wait_q; wait_q;
    scl = 1'b0; wait_q;
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; wait_q;
    scl = 1'b1; wait_q;
    b = sda_line; wait_q;
    scl = 1'b0; wait_q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
  endtask

  task automatic case1(input string p);
    logic a0, a1, a2;
    snap;
    i2c_start;
    write_byte(8'hCC, a0);
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    i2c_stop;
    checkOutput({p, "_start_cnt"}, cnt_start - s_start, 1);
    checkOutput({p, "_sel"}, sel_o, 0);
    checkOutput({p, "_rw"}, rw_o, 0);
    checkOutput({p, "_acks"}, {a0, a1, a2}, 3'b000);
    checkOutput({p, "_rx_cnt"}, cnt_rx - s_rx, 2);
    checkOutput({p, "_rx0"}, rx_log[s_rx[3:0]], 8'hA5);
    checkOutput({p, "_rx1"}, rx_log[4'(s_rx + 1)], 8'h3C);
    checkOutput({p, "_stop_cnt"}, cnt_stop - s_stop, 1);
  endtask

  initial begin
    logic       ack, found;
    logic [7:0] d0, d1;
    rst = 1'b1; scl = 1'b1; sda_drv = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checkOutput("reset_outputs",
                {i2c_sda_o, i2c_sda_oe, rx_data_o, rx_valid_o, tx_ready_o, sel_o, rw_o,
                 start_o, stop_o, tx_nack_o, tx_underrun_o}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] case 1: three-byte write to 0x66");
    case1("c1");

    $display("[TB] case 2: read from 0x68 with underrun and NACK");
    snap;
    applyStimulus(1'b1, 1'b1, 8'h5A);
    i2c_start;
    write_byte(8'hD1, ack);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("c2_addr_ack", ack, 0);
    checkOutput("c2_sel", sel_o, 2);
    checkOutput("c2_rw", rw_o, 1);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checkOutput("c2_byte0", d0, 8'h5A);
    checkOutput("c2_byte1", d1, 8'hFF);
    checkOutput("c2_oe_released", i2c_sda_oe, 0);
    i2c_stop;
    checkOutput("c2_tx_ready_cnt", cnt_txr - s_txr, 1);
    checkOutput("c2_underrun_cnt", cnt_und - s_und, 1);
    checkOutput("c2_nack_cnt", cnt_nack - s_nack, 1);
    checkOutput("c2_stop_cnt", cnt_stop - s_stop, 1);

    $display("[TB] case 3: address 0x6A outside the window");
    snap;
    i2c_start;
    write_byte(8'hD4, d0[0]);
    write_byte(8'h11, d0[1]);
    i2c_stop;
    checkOutput("c3_acks", d0[1:0], 2'b11);
    checkOutput("c3_oe_cycles", cnt_oe - s_oe, 0);
    checkOutput("c3_start_cnt", cnt_start - s_start, 0);
    checkOutput("c3_rx_cnt", cnt_rx - s_rx, 0);
    checkOutput("c3_stop_cnt", cnt_stop - s_stop, 0);

    $display("[TB] case 4: write to 0x67 with back-pressure");
    snap;
    i2c_start;
    write_byte(8'hCE, d0[0]);
    write_byte(8'h42, d0[1]);
    applyStimulus(1'b0, 1'b0, 8'h00);
    write_byte(8'h99, d0[2]);
    applyStimulus(1'b1, 1'b0, 8'h00);
    write_byte(8'h77, d0[3]);
    i2c_stop;
    checkOutput("c4_sel", sel_o, 1);
    checkOutput("c4_acks", d0[3:0], 4'b1100);
    checkOutput("c4_rx_cnt", cnt_rx - s_rx, 1);
    checkOutput("c4_rx0", rx_log[s_rx[3:0]], 8'h42);
    checkOutput("c4_stop_cnt", cnt_stop - s_stop, 1);

    $display("[TB] case 5: write then repeated START read");
    snap;
    i2c_start;
    write_byte(8'hCC, d0[0]);
    checkOutput("c5_sel_first", sel_o, 0);
    write_byte(8'h10, d0[1]);
    i2c_rstart;
    write_byte(8'hCF, d0[2]);
    checkOutput("c5_sel_second", {sel_o, rw_o}, {3'd1, 1'b1});
    read_byte(1'b1, d1);
    i2c_stop;
    checkOutput("c5_acks", d0[2:0], 3'b000);
    checkOutput("c5_read_byte", d1, 8'hFF);
    checkOutput("c5_start_cnt", cnt_start - s_start, 2);
    checkOutput("c5_stop_cnt", cnt_stop - s_stop, 1);
    checkOutput("c5_rx0", rx_log[s_rx[3:0]], 8'h10);
    checkOutput("c5_nack_underrun", {32'(cnt_nack - s_nack), 32'(cnt_und - s_und)} == {32'd1, 32'd1}, 1);

    $display("[TB] case 6: reset during a read while SDA is pulled low");
    applyStimulus(1'b1, 1'b1, 8'h00);
    i2c_start;
    write_byte(8'hD1, ack);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (i2c_sda_oe) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("c6_oe_driven", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("c6_oe_after_rst", i2c_sda_oe, 0);
    checkOutput("c6_pulses_after_rst",
                {rx_valid_o, tx_ready_o, start_o, stop_o, tx_nack_o, tx_underrun_o}, 0);
    @(negedge clk);
    scl = 1'b1; sda_drv = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    case1("c6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_multi.md
Name: i2c_target_multi

Overview:
Parametrised I2C target that answers a contiguous window of NUM_ADDR 7-bit addresses. It reports which address matched and supports both write and read transfers with byte-level valid/ready handshakes. It includes its own input synchronisers, START/STOP detection, open-drain SDA drive, controller-ACK/NACK tracking on reads, TX underrun fill, and RX back-pressure via NACK. It sits between the board I2C pins and a register/mailbox block in fabric.

Parameters:
BASE_ADDR, 7'h66, first 7-bit target address (R/W bit excluded).
NUM_ADDR, 4, number of consecutive addresses answered; range 1..8; addresses above 7'h7F do not exist (no wrap).
SYNC_STAGES, 2, flops in the SCL/SDA synchroniser chains; minimum 2.
TX_DEFAULT, 8'hFF, byte transmitted when a read byte is due and tx_valid_i is low.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i2c_scl_i  in  1  raw SCL pin
i2c_sda_i  in  1  raw SDA pin
i2c_sda_o  out  1  constant 0 (open-drain)
i2c_sda_oe  out  1  1 = pull SDA low
rx_data_o  out  8  received write byte
rx_valid_o  out  1  one-cycle pulse, rx_data_o valid
rx_ready_i  in  1  consumer can accept; sampled when the byte completes
tx_data_i  in  8  next read byte
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  one-cycle pulse, tx_data_i consumed this cycle
sel_o  out  3  matched index (address − BASE_ADDR); held until next match
rw_o  out  1  R/W bit of the matched address byte
start_o  out  1  pulse on address match
stop_o  out  1  pulse on STOP ending a matched transaction
tx_nack_o  out  1  pulse when the controller NACKs a read byte
tx_underrun_o  out  1  pulse when TX_DEFAULT is loaded

Behaviour:
- Reset: all outputs 0, including i2c_sda_oe. State is IDLE. Synchroniser flops reset to 1 so no false edges appear. Reset mid-byte releases SDA on the next clock edge.
- SCL and SDA each pass through SYNC_STAGES flops. Edges are detected on the synchronised values.
- START = synced SDA falls while SCL is high. STOP = synced SDA rises while SCL is high.
- Bits are sampled on a synced SCL rise. i2c_sda_oe changes only on the clock after a synced SCL fall, except on START/STOP/reset, which release SDA immediately.
- START/STOP have priority over every state. START (or repeated START) goes to ADDR and clears the bit counter. STOP goes to IDLE.
- stop_o pulses only if a match occurred since the last STOP.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, SKIP.
- ADDR: shift in 8 bits, MSB first.
  - After the 8th rise, compare addr[7:1] with BASE_ADDR..BASE_ADDR+NUM_ADDR−1.
  - Match: that cycle pulse start_o and update sel_o and rw_o. At the next SCL fall assert oe (ACK); go to ADDR_ACK.
  - No match (including general call 0x00): go to SKIP and never drive.
- ADDR_ACK: at the SCL fall ending the ACK:
  - rw=0: release SDA and go to WR_DATA.
  - rw=1: load a TX byte and drive bit 7; go to RD_DATA.
- WR_DATA: after the 8th rise, sample rx_ready_i.
  - If 1: pulse rx_valid_o with the byte, ACK at the next fall, go to WR_ACK, then back to WR_DATA after the 9th fall.
  - If 0: no pulse, SDA stays released (NACK), go to SKIP.
- TX load: if tx_valid_i=1, latch tx_data_i and pulse tx_ready_o. Otherwise latch TX_DEFAULT and pulse tx_underrun_o.
- RD_DATA: oe = ~bit, MSB first, advancing on each SCL fall. At the 8th fall release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the 9th rise.
  - Low (ACK): at the next fall load the next byte and drive; go to RD_DATA.
  - High (NACK): pulse tx_nack_o, go to SKIP with SDA released.
- SKIP: idle until START/STOP.
- Simultaneous START and a byte completion in the same cycle: START wins, with no rx_valid_o and no start_o.

Test Plan:
1. BASE=0x66, NUM=4. START, 0xCC, 0xA5, 0x3C, STOP -> start_o once with sel_o=0, rw_o=0. oe=1 during all three 9th clocks. rx_valid_o pulses with 0xA5 then 0x3C. stop_o once.
2. START, 0xD1 (addr 0x68 read). tx_valid_i=1 with 0x5A for byte 1, tx_valid_i=0 for byte 2. Controller ACKs byte 1, NACKs byte 2 -> sel_o=2, rw_o=1. SDA reads 0x5A then 0xFF. tx_ready_o once, tx_underrun_o once, tx_nack_o once, SDA released afterwards.
3. START, 0xD4 (0x6A, outside window), 0x11, STOP -> oe never 1. No start_o, rx_valid_o or stop_o.
4. Write to 0x67 with rx_ready_i=0 during the 2nd data byte -> 1st byte ACKed with a pulse. 2nd byte NACKed with no pulse. Further bytes ignored until STOP, and stop_o pulses.
5. START 0xCC, 0x10, repeated START 0xCF (0x67 read), one byte NACKed, STOP -> start_o twice (sel 0 then 1), stop_o once.
6. rst asserted mid-read while oe=1 -> oe=0 next cycle and all pulse outputs 0. A subsequent case-1 transaction passes.
